// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer with head/tail pointer management
// and a multi-ported entry store (two decode read ports, one completion write
// port, one commit read port). Tags are slot index + 1; tag 0 means "no entry".
// Optional feature macro: ROB_BYPASS_EN forwards a same-cycle completion write
// to a matching decode read.
module reorder_buffer #(
    parameter int ROBsize  = 32,
    parameter int addrSize = $clog2(ROBsize)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [addrSize:0]   decodeReadAddr1_i,
    input  logic [addrSize:0]   decodeReadAddr2_i,
    output logic [64:0]         decodeReadData1_o,
    output logic [64:0]         decodeReadData2_o,
    input  logic                updateTail_i,
    input  logic [7:0]          decodeWriteData_i,
    output logic [addrSize:0]   nextTail_o,
    output logic                stall_o,
    input  logic [addrSize:0]   completionWriteAddr_i,
    input  logic                completionWriteEn_i,
    input  logic [69:0]         completionWriteData_i,
    input  logic                updateHead_i,
    output logic [addrSize:0]   head_o,
    output logic [77:0]         commitReadData_o
);

    localparam logic [addrSize:0] FULL_COUNT = (addrSize+1)'(ROBsize);

    logic [77:0]         entries [ROBsize];
    logic [addrSize-1:0] head;
    logic [addrSize-1:0] tail;
    logic [addrSize:0]   count;

    logic                do_alloc;
    logic                do_retire;
    logic                do_complete;
    logic [addrSize-1:0] comp_idx;
    logic [addrSize-1:0] rd_idx1;
    logic [addrSize-1:0] rd_idx2;

    assign stall_o     = (count == FULL_COUNT);
    assign do_alloc    = updateTail_i & ~stall_o;
    assign do_retire   = updateHead_i & (count != '0);
    assign do_complete = completionWriteEn_i & (completionWriteAddr_i != '0);

    // Tag-to-slot conversion; tag 0 is filtered separately so its wrap is harmless.
    assign comp_idx = addrSize'(completionWriteAddr_i - 1'b1);
    assign rd_idx1  = addrSize'(decodeReadAddr1_i - 1'b1);
    assign rd_idx2  = addrSize'(decodeReadAddr2_i - 1'b1);

    assign nextTail_o       = {1'b0, tail} + 1'b1;
    assign head_o           = {1'b0, head} + 1'b1;
    assign commitReadData_o = entries[head];

    // Pointer and occupancy update; a refused allocation never touches count.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_alloc)
                tail <= tail + 1'b1;
            if (do_retire)
                head <= head + 1'b1;
            count <= count + {{addrSize{1'b0}}, do_alloc} - {{addrSize{1'b0}}, do_retire};
        end
    end

    // Entry store; later statements win so same-entry priority is retire > allocate > complete.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < ROBsize; i++)
                entries[i] <= '0;
        end else begin
            if (do_complete)
                entries[comp_idx][69:0] <= completionWriteData_i;
            if (do_alloc)
                entries[tail] <= {decodeWriteData_i, 70'd0};
            if (do_retire)
                entries[head] <= '0;
        end
    end

    // Decode operand reads, with optional same-cycle completion forwarding.
    always_comb begin
        decodeReadData1_o = '0;
        decodeReadData2_o = '0;
        if (decodeReadAddr1_i != '0)
            decodeReadData1_o = entries[rd_idx1][64:0];
        if (decodeReadAddr2_i != '0)
            decodeReadData2_o = entries[rd_idx2][64:0];
`ifdef ROB_BYPASS_EN
        if (do_complete && (decodeReadAddr1_i == completionWriteAddr_i))
            decodeReadData1_o = completionWriteData_i[64:0];
        if (do_complete && (decodeReadAddr2_i == completionWriteAddr_i))
            decodeReadData2_o = completionWriteData_i[64:0];
`else
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer at ROBsize = 8.
module tb_reorder_buffer;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [AW:0]   decodeReadAddr1_i;
    logic [AW:0]   decodeReadAddr2_i;
    logic [64:0]   decodeReadData1_o;
    logic [64:0]   decodeReadData2_o;
    logic          updateTail_i;
    logic [7:0]    decodeWriteData_i;
    logic [AW:0]   nextTail_o;
    logic          stall_o;
    logic [AW:0]   completionWriteAddr_i;
    logic          completionWriteEn_i;
    logic [69:0]   completionWriteData_i;
    logic          updateHead_i;
    logic [AW:0]   head_o;
    logic [77:0]   commitReadData_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW:0]  tag;
        logic [69:0]  data;
        logic [64:0]  expect_rd;
    } comp_vec_t;

    comp_vec_t  vecs [5];
    logic [64:0] sb_q [$];

    reorder_buffer #(.ROBsize(N)) dut (
        .clk_i                 (clk_i),
        .reset_i               (reset_i),
        .decodeReadAddr1_i     (decodeReadAddr1_i),
        .decodeReadAddr2_i     (decodeReadAddr2_i),
        .decodeReadData1_o     (decodeReadData1_o),
        .decodeReadData2_o     (decodeReadData2_o),
        .updateTail_i          (updateTail_i),
        .decodeWriteData_i     (decodeWriteData_i),
        .nextTail_o            (nextTail_o),
        .stall_o               (stall_o),
        .completionWriteAddr_i (completionWriteAddr_i),
        .completionWriteEn_i   (completionWriteEn_i),
        .completionWriteData_i (completionWriteData_i),
        .updateHead_i          (updateHead_i),
        .head_o                (head_o),
        .commitReadData_o      (commitReadData_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [77:0] act, input logic [77:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic retire_n(input int n);
        updateHead_i = 1'b1;
        for (int i = 0; i < n; i++) tick();
        updateHead_i = 1'b0;
    endtask

    initial begin
        logic [64:0] exp_rd;

        reset_i = 1'b1;
        decodeReadAddr1_i = '0;
        decodeReadAddr2_i = '0;
        updateTail_i = 1'b0;
        decodeWriteData_i = '0;
        completionWriteAddr_i = '0;
        completionWriteEn_i = 1'b0;
        completionWriteData_i = '0;
        updateHead_i = 1'b0;

        vecs[0] = '{tag: 4'd1, data: 70'd2,  expect_rd: 65'd2};
        vecs[1] = '{tag: 4'd2, data: 70'd4,  expect_rd: 65'd4};
        vecs[2] = '{tag: 4'd3, data: 70'd6,  expect_rd: 65'd6};
        vecs[3] = '{tag: 4'd4, data: 70'd8,  expect_rd: 65'd8};
        vecs[4] = '{tag: 4'd0, data: 70'd77, expect_rd: 65'd0};

        // Reset state
        tick(); tick();
        reset_i = 1'b0;
        decodeReadAddr1_i = 4'd1;
        decodeReadAddr2_i = 4'd8;
        #1;
        check("rst_stall", 78'(stall_o), 78'd0);
        check("rst_head", 78'(head_o), 78'd1);
        check("rst_next_tail", 78'(nextTail_o), 78'd1);
        check("rst_commit", commitReadData_o, 78'd0);
        check("rst_rd1", 78'(decodeReadData1_o), 78'd0);
        check("rst_rd2", 78'(decodeReadData2_o), 78'd0);

        // Four allocations, data 1..4
        for (int i = 1; i <= 4; i++) begin
            updateTail_i = 1'b1;
            decodeWriteData_i = 8'(i);
            tick();
            check("alloc_next_tail", 78'(nextTail_o), 78'(i + 1));
        end
        updateTail_i = 1'b0;
        check("alloc_head", 78'(head_o), 78'd1);
        check("alloc_commit_dec", 78'(commitReadData_o[77:70]), 78'd1);

        // Completion vectors through the scoreboard
        for (int i = 0; i < 5; i++) begin
            completionWriteEn_i = 1'b1;
            completionWriteAddr_i = vecs[i].tag;
            completionWriteData_i = vecs[i].data;
            sb_q.push_back(vecs[i].expect_rd);
            tick();
            completionWriteEn_i = 1'b0;
            decodeReadAddr1_i = vecs[i].tag;
            #1;
            exp_rd = sb_q.pop_front();
            check("complete_rd1", 78'(decodeReadData1_o), 78'(exp_rd));
        end
        decodeReadAddr2_i = 4'd4;
        #1;
        check("complete_rd2_tag4", 78'(decodeReadData2_o), 78'd8);
        check("complete_commit", commitReadData_o, {8'd1, 70'd2});

        // Retire twice
        retire_n(2);
        decodeReadAddr1_i = 4'd1;
        decodeReadAddr2_i = 4'd2;
        #1;
        check("retire_head", 78'(head_o), 78'd3);
        check("retire_commit", commitReadData_o, {8'd3, 70'd6});
        check("retire_slot0", 78'(decodeReadData1_o), 78'd0);
        check("retire_slot1", 78'(decodeReadData2_o), 78'd0);

        // Seven more allocations; the seventh meets a full buffer
        for (int i = 0; i < 7; i++) begin
            check("fill_stall", 78'(stall_o), 78'(i == 6));
            updateTail_i = 1'b1;
            decodeWriteData_i = 8'(8'h10 + i);
            tick();
        end
        updateTail_i = 1'b0;
        check("full_stall", 78'(stall_o), 78'd1);
        check("full_next_tail", 78'(nextTail_o), 78'd3);
        check("full_head_intact", commitReadData_o, {8'd3, 70'd6});

        // Retire four; stall falls after the first
        updateHead_i = 1'b1;
        tick();
        check("unstall", 78'(stall_o), 78'd0);
        tick(); tick(); tick();
        updateHead_i = 1'b0;
        check("retire4_head", 78'(head_o), 78'd7);
        check("retire4_commit", commitReadData_o, {8'h12, 70'd0});

        // Refill, then allocate and retire together while full
        for (int i = 0; i < 4; i++) begin
            updateTail_i = 1'b1;
            decodeWriteData_i = 8'(8'h20 + i);
            tick();
        end
        check("refill_stall", 78'(stall_o), 78'd1);
        updateHead_i = 1'b1;
        tick();
        updateTail_i = 1'b0;
        updateHead_i = 1'b0;
        check("both_stall", 78'(stall_o), 78'd0);
        check("both_head", 78'(head_o), 78'd8);
        check("both_next_tail", 78'(nextTail_o), 78'd7);
        updateTail_i = 1'b1;
        decodeWriteData_i = 8'h30;
        tick();
        updateTail_i = 1'b0;
        check("both_count", 78'(stall_o), 78'd1);

        // Drain completely, then retire while empty
        retire_n(8);
        check("drain_head", 78'(head_o), 78'd8);
        check("drain_commit", commitReadData_o, 78'd0);
        retire_n(1);
        check("empty_retire_head", 78'(head_o), 78'd8);
        check("empty_retire_stall", 78'(stall_o), 78'd0);
        check("empty_next_tail", 78'(nextTail_o), 78'd8);
        updateTail_i = 1'b1;
        decodeWriteData_i = 8'h44;
        tick();
        updateTail_i = 1'b0;
        check("empty_alloc_commit", commitReadData_o, {8'h44, 70'd0});
        check("tag_wrap", 78'(nextTail_o), 78'd1);

        // Same-cycle completion and read of tag 8
        completionWriteEn_i = 1'b1;
        completionWriteAddr_i = 4'd8;
        completionWriteData_i = 70'h155;
        decodeReadAddr1_i = 4'd8;
        #1;
`ifdef ROB_BYPASS_EN
        check("bypass_same_cycle", 78'(decodeReadData1_o), 78'h155);
`else
        check("no_bypass_same_cycle", 78'(decodeReadData1_o), 78'd0);
`endif
        tick();
        completionWriteEn_i = 1'b0;
        check("complete_next_cycle", 78'(decodeReadData1_o), 78'h155);
        check("complete_commit_wrap", commitReadData_o, {8'h44, 70'h155});

        // Reset mid-operation
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("midrst_head", 78'(head_o), 78'd1);
        check("midrst_next_tail", 78'(nextTail_o), 78'd1);
        check("midrst_commit", commitReadData_o, 78'd0);
        check("midrst_rd1", 78'(decodeReadData1_o), 78'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
